// File: rtl/uc_mod_param_if.sv
// uc_mod_param_if -- control/status bundle for the modulo-N universal counter.
//   master : drives load, up_down, en, sat, ovf_clr, data; observes q, tc, at_max, at_min, ovf
//   slave  : the counter itself (mirror of master)
// clk/clr are kept as plain ports on the counter, outside this bundle.
interface uc_mod_param_if #(
   parameter int WIDTH = 4
);
   logic             load;
   logic             up_down;
   logic             en;
   logic             sat;
   logic             ovf_clr;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             at_max;
   logic             at_min;
   logic             ovf;

   modport master (
      output load, up_down, en, sat, ovf_clr, data,
      input  q, tc, at_max, at_min, ovf
   );

   modport slave (
      input  load, up_down, en, sat, ovf_clr, data,
      output q, tc, at_max, at_min, ovf
   );
endinterface

// File: rtl/uc_mod_param.sv
// uc_mod_param -- parametrised modulo-(MAX_VAL+1) up/down counter with
// per-cycle wrap/saturate mode, terminal-count pulse, min/max flags and a
// sticky overflow flag.
// Ports:
//   clk  : clock, rising edge
//   clr  : asynchronous active-high reset (q=0, tc=0, ovf=0, prescaler=0)
//   bus  : uc_mod_param_if.slave
//          in  load, up_down, en, sat, ovf_clr, data[WIDTH]
//          out q[WIDTH] (reg), tc (reg), ovf (reg), at_max/at_min (comb from q)
// Optional feature: define UCM_PRESCALE_EN to divide the count enable by
// PRESCALE (a step is taken on every PRESCALE-th en cycle).
module uc_mod_param #(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = 9,
   parameter int PRESCALE = 4
) (
   input logic           clk,
   input logic           clr,
   uc_mod_param_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] q, q_nxt;
   logic             tc, tc_nxt;
   logic             ovf, ovf_nxt;
   logic             step;
   logic             boundary;

`ifdef UCM_PRESCALE_EN
   localparam int            PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre;

   // Step only on the en cycle that closes the prescale window.
   assign step = bus.en && !bus.load && (pre == PLAST);

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         pre <= '0;
      else if (bus.load)
         pre <= '0;
      else if (bus.en)
         pre <= (pre == PLAST) ? '0 : pre + 1'b1;
   end
`else
   assign step = bus.en && !bus.load;
`endif

   always_comb begin
      q_nxt    = q;
      tc_nxt   = 1'b0;
      boundary = 1'b0;
      // Clear first so a boundary event on the same edge overrides it.
      ovf_nxt  = bus.ovf_clr ? 1'b0 : ovf;
      if (bus.load) begin
         q_nxt = (bus.data > MAX) ? MAX : bus.data;
      end else if (step) begin
         if (bus.up_down) begin
            if (q < MAX) begin
               q_nxt = q + 1'b1;
            end else begin
               boundary = 1'b1;
               if (!bus.sat) begin
                  q_nxt  = '0;
                  tc_nxt = 1'b1;
               end
            end
         end else begin
            if (q != '0) begin
               q_nxt = q - 1'b1;
            end else begin
               boundary = 1'b1;
               if (!bus.sat) begin
                  q_nxt  = MAX;
                  tc_nxt = 1'b1;
               end
            end
         end
      end
      if (boundary)
         ovf_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         q   <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         q   <= q_nxt;
         tc  <= tc_nxt;
         ovf <= ovf_nxt;
      end
   end

   assign bus.q      = q;
   assign bus.tc     = tc;
   assign bus.ovf    = ovf;
   assign bus.at_max = (q == MAX);
   assign bus.at_min = (q == '0);
endmodule

// File: tb/tb_uc_mod_param.sv
// tb_uc_mod_param -- self-checking bench for uc_mod_param (WIDTH=4,
// MAX_VAL=9, PRESCALE=4). Directed scenarios plus a randomized run, all
// checked against a behavioural model of the counting rules. Scenarios that
// depend on UCM_PRESCALE_EN are compiled only when that macro is defined.
module tb_uc_mod_param;
   localparam int WIDTH    = 4;
   localparam int MAX_VAL  = 9;
   localparam int PRESCALE = 4;

   logic clk = 1'b0;
   logic clr = 1'b0;
   int   n_checks = 0;
   int   n_errs   = 0;

   // behavioural model state
   int m_q   = 0;
   bit m_tc  = 1'b0;
   bit m_ovf = 1'b0;
   int m_pre = 0;

   uc_mod_param_if #(.WIDTH(WIDTH)) bus ();

   uc_mod_param #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .PRESCALE(PRESCALE)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Apply the counting rules for one rising edge using the current inputs.
   task automatic model_edge();
      bit do_step;
      m_tc = 1'b0;
      if (bus.ovf_clr) m_ovf = 1'b0;
      if (bus.load) begin
         m_q   = (int'(bus.data) > MAX_VAL) ? MAX_VAL : int'(bus.data);
         m_pre = 0;
      end else if (bus.en) begin
`ifdef UCM_PRESCALE_EN
         do_step = (m_pre == PRESCALE - 1);
         m_pre   = (m_pre + 1) % PRESCALE;
`else
         do_step = 1'b1;
`endif
         if (do_step) begin
            if (bus.up_down ? (m_q == MAX_VAL) : (m_q == 0)) begin
               m_ovf = 1'b1;
               if (!bus.sat) begin
                  m_q  = (m_q + (bus.up_down ? 1 : MAX_VAL)) % (MAX_VAL + 1);
                  m_tc = 1'b1;
               end
            end else begin
               m_q = bus.up_down ? m_q + 1 : m_q - 1;
            end
         end
      end
   endtask

   task automatic model_clear();
      m_q = 0; m_tc = 1'b0; m_ovf = 1'b0; m_pre = 0;
   endtask

   // One clock edge; outputs are sampled 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(bit ld, bit ud, bit e, bit s, bit oc, int d);
      bus.load = ld; bus.up_down = ud; bus.en = e; bus.sat = s;
      bus.ovf_clr = oc; bus.data = WIDTH'(d);
   endtask

   task automatic test_reset();
      drive(0, 1, 0, 0, 0, 0);
      clr = 1'b1;
      #12;
      model_clear();
      n_checks++;
      if ({bus.q, bus.tc, bus.ovf, bus.at_max, bus.at_min} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_errs++;
         $display("FAIL reset: q=%0d tc=%0b ovf=%0b max=%0b min=%0b, want q=0 tc=0 ovf=0 max=0 min=1",
                  bus.q, bus.tc, bus.ovf, bus.at_max, bus.at_min);
      end
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_clr_mid();
      drive(1, 1, 0, 0, 0, 4); cyc();
      drive(0, 1, 1, 1, 0, 0); cyc();
      n_checks++;
      if (bus.q !== 4'd5) begin
         n_errs++; $display("FAIL clr_mid_pre: q=%0d want 5", bus.q);
      end
      // saturate once so ovf is set before clr
      drive(1, 1, 0, 0, 0, 9); cyc();
      drive(0, 1, 1, 1, 0, 0); cyc();
      drive(1, 1, 0, 0, 0, 5); cyc();
      drive(0, 1, 0, 0, 0, 0);
      #2 clr = 1'b1;
      #1;
      model_clear();
      n_checks++;
      if ({bus.q, bus.tc, bus.ovf, bus.at_min} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
         n_errs++;
         $display("FAIL clr_mid: q=%0d tc=%0b ovf=%0b min=%0b, want q=0 tc=0 ovf=0 min=1",
                  bus.q, bus.tc, bus.ovf, bus.at_min);
      end
      #1 clr = 1'b0;
`ifndef UCM_PRESCALE_EN
      drive(0, 1, 1, 0, 0, 0); cyc();
      n_checks++;
      if (bus.q !== 4'd1) begin
         n_errs++; $display("FAIL clr_first_step: q=%0d want 1", bus.q);
      end
`endif
   endtask

   task automatic test_wrap_up();
      int exp_q[3] = '{8, 9, 0};
      drive(1, 1, 0, 0, 1, 7); cyc();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 0, 0); cyc();
         n_checks++;
         if ({bus.q, bus.tc, bus.ovf} !== {4'(exp_q[i]), i == 2, i == 2}) begin
            n_errs++;
            $display("FAIL wrap_up[%0d]: q=%0d tc=%0b ovf=%0b, want q=%0d tc=%0b ovf=%0b",
                     i, bus.q, bus.tc, bus.ovf, exp_q[i], i == 2, i == 2);
         end
      end
      drive(0, 1, 0, 0, 0, 0); cyc();
      n_checks++;
      if ({bus.q, bus.tc, bus.ovf} !== {4'd0, 1'b0, 1'b1}) begin
         n_errs++; $display("FAIL wrap_up_hold: q=%0d tc=%0b ovf=%0b, want 0 0 1", bus.q, bus.tc, bus.ovf);
      end
   endtask

   task automatic test_sat_down();
      drive(1, 0, 0, 1, 1, 0); cyc();
      drive(0, 0, 1, 1, 0, 0); cyc();
      n_checks++;
      if ({bus.q, bus.tc, bus.ovf} !== {4'd0, 1'b0, 1'b1}) begin
         n_errs++; $display("FAIL sat_down: q=%0d tc=%0b ovf=%0b, want 0 0 1", bus.q, bus.tc, bus.ovf);
      end
      drive(0, 0, 0, 1, 1, 0); cyc();
      n_checks++;
      if (bus.ovf !== 1'b0) begin
         n_errs++; $display("FAIL ovf_clr: ovf=%0b want 0", bus.ovf);
      end
      drive(0, 0, 1, 1, 1, 0); cyc();
      n_checks++;
      if ({bus.q, bus.ovf} !== {4'd0, 1'b1}) begin
         n_errs++; $display("FAIL ovf_set_wins: q=%0d ovf=%0b, want 0 1", bus.q, bus.ovf);
      end
   endtask

   task automatic test_load();
      drive(1, 1, 0, 0, 0, 13); cyc();
      n_checks++;
      if ({bus.q, bus.at_max, bus.at_min} !== {4'd9, 1'b1, 1'b0}) begin
         n_errs++; $display("FAIL load_clamp: q=%0d max=%0b min=%0b, want 9 1 0", bus.q, bus.at_max, bus.at_min);
      end
      drive(1, 1, 1, 0, 0, 3); cyc();
      n_checks++;
      if ({bus.q, bus.tc} !== {4'd3, 1'b0}) begin
         n_errs++; $display("FAIL load_over_en: q=%0d tc=%0b, want 3 0", bus.q, bus.tc);
      end
   endtask

   task automatic test_down_wrap();
      drive(1, 0, 0, 0, 1, 0); cyc();
`ifdef UCM_PRESCALE_EN
      for (int i = 0; i < PRESCALE - 1; i++) begin
         drive(0, 0, 1, 0, 0, 0); cyc();
      end
`endif
      drive(0, 0, 1, 0, 0, 0); cyc();
      n_checks++;
      if ({bus.q, bus.tc, bus.ovf, bus.at_max} !== {4'd9, 1'b1, 1'b1, 1'b1}) begin
         n_errs++; $display("FAIL down_wrap: q=%0d tc=%0b ovf=%0b max=%0b, want 9 1 1 1",
                            bus.q, bus.tc, bus.ovf, bus.at_max);
      end
      drive(0, 0, 0, 0, 0, 0); cyc();
      n_checks++;
      if ({bus.q, bus.tc} !== {4'd9, 1'b0}) begin
         n_errs++; $display("FAIL down_wrap_hold: q=%0d tc=%0b, want 9 0", bus.q, bus.tc);
      end
   endtask

`ifdef UCM_PRESCALE_EN
   task automatic test_prescale();
      drive(1, 1, 0, 0, 0, 0); cyc();
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1, 1, 0, 0, 0); cyc();
         n_checks++;
         if (bus.q !== 4'(i / 4)) begin
            n_errs++; $display("FAIL prescale[%0d]: q=%0d want %0d", i, bus.q, i / 4);
         end
      end
      drive(0, 1, 1, 0, 0, 0); cyc();
      drive(0, 1, 1, 0, 0, 0); cyc();
      drive(1, 1, 0, 0, 0, 5); cyc();
      for (int i = 1; i <= 4; i++) begin
         drive(0, 1, 1, 0, 0, 0); cyc();
         n_checks++;
         if (bus.q !== 4'(i == 4 ? 6 : 5)) begin
            n_errs++; $display("FAIL prescale_reload[%0d]: q=%0d want %0d", i, bus.q, i == 4 ? 6 : 5);
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
               1'($urandom), $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
         cyc();
         n_checks++;
         if ({bus.q, bus.tc, bus.ovf, bus.at_max, bus.at_min} !==
             {4'(m_q), m_tc, m_ovf, m_q == MAX_VAL, m_q == 0}) begin
            n_errs++;
            $display("FAIL random[%0d]: q=%0d tc=%0b ovf=%0b max=%0b min=%0b, want q=%0d tc=%0b ovf=%0b",
                     i, bus.q, bus.tc, bus.ovf, bus.at_max, bus.at_min, m_q, m_tc, m_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clr_mid();
      test_wrap_up();
      test_sat_down();
      test_load();
      test_down_wrap();
`ifdef UCM_PRESCALE_EN
      test_prescale();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
